// File: rtl/line_fetch.sv
// line_fetch: on each clk40 line request, reads one line of 16-bit pixels from a
// pipelined memory read port and streams them into the scan-out FIFO write side.
module line_fetch #(
    parameter int LINE_PIXELS = 800,
    parameter int LINE_STRIDE = 1024,
    parameter int FRAME_BASE  = 0,
    parameter int ADDR_WIDTH  = 22,
    parameter int MAX_PENDING = 8
) (
    input  logic                  clk100,
    input  logic                  reset,
    input  logic                  lineRequest,
    input  logic [9:0]            nextVPos,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRead,
    input  logic                  memWaitRequest,
    input  logic [15:0]           memReadData,
    input  logic                  memReadDataValid,
    output logic [15:0]           fifoData,
    output logic                  fifoWrReq,
    input  logic                  fifoFull,
    input  logic                  fifoAlmostFull,
    output logic                  busy,
    output logic                  lineDone,
    output logic                  overrun,
    output logic                  overflow,
    output logic [1:0]            dbgState
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } fetchState;

    localparam logic [9:0]            LINE_CNT  = 10'(LINE_PIXELS);
    localparam logic [3:0]            PEND_MAX  = 4'(MAX_PENDING);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(LINE_STRIDE);

    fetchState             state, stateNext;
    logic [2:0]            reqSync;  // [1:0] synchronizer, [2] edge history
    logic                  start;
    logic [9:0]            vposReg, issued, returned;
    logic [3:0]            pending;
    logic [ADDR_WIDTH-1:0] lineBase;
    logic                  readHeld;
    logic                  accept, retValid;

    // memRead/memWaitRequest form a valid/ready pair: a read transfers on
    // memRead & ~memWaitRequest, and once raised memRead and memAddr hold until then.
    assign accept   = memRead & ~memWaitRequest;
    assign retValid = memReadDataValid & ((state == ISSUE) | (state == DRAIN));
    assign memAddr  = lineBase + ADDR_WIDTH'(issued);
    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            reqSync <= '0;
            start   <= 1'b0;
        end else begin
            reqSync <= {reqSync[1:0], lineRequest};
            start   <= reqSync[1] & ~reqSync[2];
        end
    end

    always_comb begin
        stateNext = state;
        memRead   = 1'b0;
        lineDone  = 1'b0;
        case (state)
            IDLE:  if (start) stateNext = SETUP;
            SETUP: stateNext = ISSUE;
            ISSUE: begin
                memRead = (issued < LINE_CNT) &&
                          (readHeld || ((pending < PEND_MAX) && !fifoAlmostFull));
                if (memRead && !memWaitRequest && (issued == LINE_CNT - 10'd1))
                    stateNext = DRAIN;
            end
            DRAIN: begin
                // Wait for the final write strobe to retire so lineDone trails it.
                if ((returned == LINE_CNT) && !fifoWrReq) begin
                    lineDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vposReg   <= '0;
            lineBase  <= '0;
            issued    <= '0;
            returned  <= '0;
            pending   <= '0;
            readHeld  <= 1'b0;
            fifoData  <= '0;
            fifoWrReq <= 1'b0;
            overrun   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            readHeld  <= memRead & memWaitRequest;
            fifoWrReq <= retValid;
            if (retValid) fifoData <= memReadData;
            if (start && (state == IDLE)) vposReg <= nextVPos;
            if (start && (state != IDLE)) overrun <= 1'b1;
            if (fifoWrReq && fifoFull) overflow <= 1'b1;
            if (state == SETUP) begin
                lineBase <= BASE_ADDR + ADDR_WIDTH'(vposReg) * STRIDE;
                issued   <= '0;
                returned <= '0;
                pending  <= '0;
            end else begin
                if (accept) issued <= issued + 10'd1;
                if (retValid) returned <= returned + 10'd1;
                case ({accept, retValid})
                    2'b10:   pending <= pending + 4'd1;
                    2'b01:   pending <= pending - 4'd1;
                    default: pending <= pending;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_line_fetch.sv
// Bench for line_fetch: a behavioural memory with configurable latency and stall
// rate feeds the block; table-driven line fetches plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_line_fetch;
    localparam int AW   = 22;
    localparam int PIX  = 800;
    localparam int MAXP = 8;

    logic          clk100 = 1'b0;
    logic          reset = 1'b1;
    logic          lineRequest = 1'b0;
    logic [9:0]    nextVPos = '0;
    logic [AW-1:0] memAddr;
    logic          memRead;
    logic          memWaitRequest = 1'b0;
    logic [15:0]   memReadData = '0;
    logic          memReadDataValid = 1'b0;
    logic [15:0]   fifoData;
    logic          fifoWrReq;
    logic          fifoFull = 1'b0;
    logic          fifoAlmostFull = 1'b0;
    logic          busy, lineDone, overrun, overflow;
    logic [1:0]    dbgState;

    always #5 clk100 = ~clk100;

    line_fetch #(
        .LINE_PIXELS(PIX), .LINE_STRIDE(1024), .FRAME_BASE(0),
        .ADDR_WIDTH(AW), .MAX_PENDING(MAXP)
    ) dut (
        .clk100(clk100), .reset(reset), .lineRequest(lineRequest), .nextVPos(nextVPos),
        .memAddr(memAddr), .memRead(memRead), .memWaitRequest(memWaitRequest),
        .memReadData(memReadData), .memReadDataValid(memReadDataValid),
        .fifoData(fifoData), .fifoWrReq(fifoWrReq), .fifoFull(fifoFull),
        .fifoAlmostFull(fifoAlmostFull), .busy(busy), .lineDone(lineDone),
        .overrun(overrun), .overflow(overflow), .dbgState(dbgState)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } retEntry;

    retEntry       retQ[$];
    logic [15:0]   exp_q[$];
    int            cyc = 0, lat = 1, waitPct = 0;
    bit            afForce = 0, fullForce = 0, monOn = 0;
    int            accCnt = 0, valCnt = 0, wrCnt = 0, doneCnt = 0, maxPend = 0;
    int            firstAcc = 0, lastAcc = 0;
    bit            lineFirst = 0, prevStalled = 0, prevValid = 0;
    logic [AW-1:0] expAddr = '0, firstAddr = '0, prevAddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pixelOf(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 22'd7;
        return t[15:0] ^ 16'h5AC3;
    endfunction

    // Memory model and monitor: drives inputs on the falling edge, samples #1 later.
    always @(negedge clk100) begin : monitor
        int      bPend;
        retEntry e;
        cyc++;
        bPend = accCnt - valCnt;
        if (retQ.size() > 0 && retQ[0].due <= cyc) begin
            e = retQ.pop_front();
            memReadDataValid = 1'b1;
            memReadData      = e.data;
            valCnt++;
        end else begin
            memReadDataValid = 1'b0;
            memReadData      = 16'h0;
        end
        memWaitRequest = (waitPct > 0) && ($urandom_range(99, 0) < waitPct);
        fifoAlmostFull = afForce;
        fifoFull       = fullForce;
        #1;
        if (fifoWrReq) begin
            wrCnt++;
            if (exp_q.size() == 0) check("stale_write", {31'b0, fifoWrReq}, 32'd0);
            else check("wr_data", fifoData, exp_q.pop_front());
        end
        if (monOn) begin
            check("wr_latency", fifoWrReq, prevValid);
            if (bPend > maxPend) maxPend = bPend;
            if (bPend >= MAXP) check("pending_throttle", memRead, 0);
        end
        if (prevStalled) begin
            check("stall_read", memRead, 1);
            check("stall_addr", memAddr, prevAddr);
        end
        if (afForce && !prevStalled) check("af_block", memRead, 0);
        if (memRead && !memWaitRequest) begin
            check("read_addr", memAddr, expAddr);
            if (lineFirst) begin
                firstAddr = memAddr;
                firstAcc  = cyc;
                lineFirst = 0;
            end
            lastAcc = cyc;
            exp_q.push_back(pixelOf(memAddr));
            retQ.push_back('{due: cyc + lat, data: pixelOf(memAddr)});
            expAddr++;
            accCnt++;
        end
        if (lineDone) doneCnt++;
        prevStalled = memRead && memWaitRequest;
        prevAddr    = memAddr;
        prevValid   = memReadDataValid;
    end

    task automatic tick();
        @(posedge clk100);
        #3;
    endtask

    task automatic newLine(input logic [AW-1:0] base, input int l, input int w);
        lat = l; waitPct = w; expAddr = base;
        wrCnt = 0; doneCnt = 0; accCnt = 0; valCnt = 0; maxPend = 0; lineFirst = 1;
    endtask

    task automatic pulseRequest(input logic [9:0] vpos);
        nextVPos = vpos;
        lineRequest = 1'b1;
        repeat (6) tick();
        lineRequest = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (doneCnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, doneCnt, 1);
    endtask

    task automatic waitWrites(input int target, input int budget);
        int n = 0;
        while (wrCnt < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_writes", {31'b0, wrCnt >= target}, 1);
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_addr"}, memAddr, 0);
        check({name, "_ctl"}, {fifoData, memRead, fifoWrReq, busy, lineDone,
                                overrun, overflow, dbgState}, 0);
    endtask

    typedef struct {
        logic [9:0]    vpos;
        int            lat;
        int            waitPct;
        logic [AW-1:0] expBase;
        int            expMaxPend;  // -1: only bounded by MAXP
        int            expSpan;     // -1: accept spacing not fixed
    } lineVec;

    lineVec vecs[4];

    initial begin : seq
        logic [4:0] expRd;
        logic [4:0] expBusy;
        int a0, w0, n;
        expRd   = 5'b10000;
        expBusy = 5'b11000;
        vecs[0] = '{vpos: 10'd3,    lat: 1,  waitPct: 0,  expBase: 22'd3072,    expMaxPend: 1,  expSpan: 799};
        vecs[1] = '{vpos: 10'd7,    lat: 12, waitPct: 0,  expBase: 22'd7168,    expMaxPend: 8,  expSpan: -1};
        vecs[2] = '{vpos: 10'd1023, lat: 2,  waitPct: 50, expBase: 22'd1047552, expMaxPend: -1, expSpan: -1};
        vecs[3] = '{vpos: 10'd5,    lat: 1,  waitPct: 25, expBase: 22'd5120,    expMaxPend: -1, expSpan: -1};

        repeat (3) tick();
        checkResetOutputs("por");
        reset = 1'b0;
        monOn = 1;
        repeat (3) tick();

        for (int i = 0; i < 4; i++) begin
            newLine(vecs[i].expBase, vecs[i].lat, vecs[i].waitPct);
            nextVPos = vecs[i].vpos;
            lineRequest = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("start_read_v%0d_c%0d", i, k), memRead, expRd[k]);
                check($sformatf("start_busy_v%0d_c%0d", i, k), busy, expBusy[k]);
            end
            lineRequest = 1'b0;
            waitDone($sformatf("line_done_v%0d", i), 6000);
            check($sformatf("writes_v%0d", i), wrCnt, PIX);
            check($sformatf("reads_v%0d", i), accCnt, PIX);
            check($sformatf("first_addr_v%0d", i), firstAddr, vecs[i].expBase);
            check($sformatf("flags_v%0d", i), {overrun, overflow, busy}, 0);
            check($sformatf("exp_empty_v%0d", i), exp_q.size(), 0);
            if (vecs[i].expMaxPend >= 0)
                check($sformatf("max_pend_v%0d", i), maxPend, vecs[i].expMaxPend);
            else
                check($sformatf("pend_bound_v%0d", i), {31'b0, maxPend <= MAXP}, 1);
            if (vecs[i].expSpan >= 0)
                check($sformatf("span_v%0d", i), lastAcc - firstAcc, vecs[i].expSpan);
        end

        // almostFull throttle mid-line, then a forced fifoFull during writes
        newLine(22'd2048, 3, 0);
        pulseRequest(10'd2);
        waitWrites(200, 2000);
        check("overflow_pre", overflow, 0);
        afForce = 1;
        repeat (100) tick();
        check("af_inflight_written", wrCnt, accCnt);
        check("af_busy", busy, 1);
        a0 = accCnt;
        afForce = 0;
        repeat (10) tick();
        check("af_resume", {31'b0, accCnt > a0}, 1);
        fullForce = 1;
        repeat (2) tick();
        fullForce = 0;
        tick();
        check("overflow_set", overflow, 1);
        waitDone("af_line_done", 4000);
        check("af_writes", wrCnt, PIX);
        check("overflow_sticky", overflow, 1);

        // second request while draining
        newLine(22'd4096, 12, 0);
        pulseRequest(10'd4);
        n = 0;
        while (dbgState != 2'd3 && n < 4000) begin
            tick();
            n++;
        end
        check("reach_drain", dbgState, 3);
        lineRequest = 1'b1;
        repeat (4) tick();
        check("overrun_set", overrun, 1);
        lineRequest = 1'b0;
        waitDone("overrun_line_done", 4000);
        check("overrun_writes", wrCnt, PIX);
        repeat (30) tick();
        check("overrun_idle", {busy, dbgState}, 0);
        check("overrun_no_reads", accCnt, PIX);
        check("overrun_one_done", doneCnt, 1);
        check("overrun_sticky", {overrun, overflow}, 3);

        // a level held high produces exactly one line
        newLine(22'd6144, 1, 0);
        nextVPos = 10'd6;
        lineRequest = 1'b1;
        waitDone("hold_line_done", 4000);
        repeat (40) tick();
        check("hold_one_line", doneCnt, 1);
        check("hold_reads", accCnt, PIX);
        check("hold_idle", busy, 0);
        lineRequest = 1'b0;
        repeat (5) tick();

        // reset mid-line, stale returns, fresh line from address 0
        newLine(22'd9216, 12, 0);
        pulseRequest(10'd9);
        waitWrites(400, 2000);
        reset = 1'b1;
        monOn = 0;
        exp_q.delete();
        tick();
        checkResetOutputs("mid_reset");
        tick();
        reset = 1'b0;
        w0 = wrCnt;
        repeat (30) tick();
        check("stale_discard", wrCnt, w0);
        check("stale_idle", {busy, memRead}, 0);
        newLine(22'd0, 1, 0);
        monOn = 1;
        pulseRequest(10'd0);
        waitDone("post_reset_done", 4000);
        check("post_reset_first_addr", firstAddr, 0);
        check("post_reset_writes", wrCnt, PIX);
        check("post_reset_flags", {overrun, overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_fetch.md
# line_fetch

Upstream stage of the scan-out FIFO, in the clk100 domain. For each line request raised by the clk40 frame timing (hsync while the next frame line is active), it reads one line of 16-bit pixels from a pipelined memory read port and writes them into the write side of the dual-clock scan-out FIFO. Together with the `line_fetch` FIFO interface, it replaces the synthetic counter pattern as the FIFO's data source.

## Interface
- `LINE_PIXELS`, 800: pixels fetched per line.
- `LINE_STRIDE`, 1024: address step between consecutive lines, in words.
- `FRAME_BASE`, 0: word address of line 0.
- `ADDR_WIDTH`, 22: memory word-address width.
- `MAX_PENDING`, 8: maximum accepted-but-unreturned reads (1..15).
- `clk100` input 1: sole clock; every register in the block is clocked by it.
- `reset` input 1: asynchronous, active-high.
- `lineRequest` input 1: asynchronous level from the clk40 domain (hsync & nextFrameActive).
- `nextVPos` input 10: line number from the clk40 domain; stable while `lineRequest` is high.
- `memAddr` output ADDR_WIDTH: read word address.
- `memRead` output 1: read request.
- `memWaitRequest` input 1: stall; a read is accepted on `memRead & ~memWaitRequest`.
- `memReadData` input 16: returned pixel.
- `memReadDataValid` input 1: `memReadData` is valid this cycle; returns arrive in order.
- `fifoData` output 16: FIFO write data.
- `fifoWrReq` output 1: FIFO write strobe.
- `fifoFull` input 1: FIFO wrfull.
- `fifoAlmostFull` input 1: FIFO free space is ≤ MAX_PENDING.
- `busy` output 1: high in every state except IDLE.
- `lineDone` output 1: one-cycle pulse when the last pixel of a line has been written.
- `overrun` output 1: sticky flag; a line request arrived while busy.
- `overflow` output 1: sticky flag; a write was issued while `fifoFull` was high.

## Operation
- `lineRequest` passes through a two-flop synchronizer and then a rising-edge detector; the edge produces `start`.
- States and transitions:
  - IDLE: on `start`, capture `nextVPos` into `vposReg` and go to SETUP.
  - SETUP: one cycle; `lineBase <= FRAME_BASE + vposReg*LINE_STRIDE`, truncated to ADDR_WIDTH. Clear `issued`, `returned` and `pending`. Go to ISSUE.
  - ISSUE: `memRead` is high when `issued < LINE_PIXELS`, `pending < MAX_PENDING` and `~fifoAlmostFull`. `memAddr = lineBase + issued`, modulo 2^ADDR_WIDTH.
    - Once asserted, `memRead` and `memAddr` are held stable until the read is accepted, regardless of `fifoAlmostFull`.
    - On acceptance, `issued++`.
    - When `issued == LINE_PIXELS` after acceptance, go to DRAIN.
  - DRAIN: when `returned == LINE_PIXELS`, pulse `lineDone` and go to IDLE.
- Return path, active in ISSUE and DRAIN:
  - On `memReadDataValid`, register `fifoData <= memReadData` and `fifoWrReq <= 1`, then `returned++`.
  - No write is gated by `fifoFull`. If `fifoFull` is high in the cycle `fifoWrReq` is high, set `overflow`.
  - `memReadDataValid` in IDLE or SETUP is discarded.
- `pending` counts +1 on acceptance and −1 on `memReadDataValid`. When both happen in the same cycle, `pending` is unchanged.
- A `start` in any state other than IDLE is ignored and sets `overrun`; the current line completes normally.
- `overrun` and `overflow` clear only on `reset`.
- Counter widths: `issued` and `returned` are 10 bits and are sized for LINE_PIXELS ≤ 1023; `pending` is 4 bits.

## Timing
- Reset value of every output and register is 0; the state is IDLE.
- `reset` asserted mid-line aborts immediately. Data returning after `reset` deasserts is discarded because the block is in IDLE.
- `lineRequest` rising at clk100 edge N: `start` at N+2, SETUP at N+3, earliest `memRead` at N+4.
- Data path: `memReadDataValid` in cycle M gives `fifoWrReq` in cycle M+1; the latency is exactly 1 cycle.
- Throughput: one read per cycle while there is no stall or throttle.
- `lineDone` is asserted in the cycle after the final `fifoWrReq`.
- `lineRequest` must return low before a new `start` can occur; a level held high produces exactly one line.
- `busy` is high from the SETUP cycle through the `lineDone` cycle inclusive.

## Test plan
- Single-cycle-latency memory, `nextVPos` = 3, defaults -> 800 reads at addresses 3072..3871 issued back-to-back, 800 `fifoWrReq` carrying the data in order, one `lineDone`, `overrun` = `overflow` = 0.
- Memory latency of 12 cycles -> `pending` never exceeds 8, `memRead` drops while `pending` is 8, all 800 words are delivered, and `lineDone` follows the last write.
- `memWaitRequest` random at 50% -> `memAddr` is stable during every stall, no address is skipped or duplicated, and addresses are contiguous.
- `fifoAlmostFull` held high for 100 cycles mid-line -> no new `memRead` assertions, in-flight reads still written, issuing resumes when it drops; `fifoFull` forced high during one write -> `overflow` = 1 and remains set.
- Second `lineRequest` edge during DRAIN -> `overrun` = 1, exactly 800 writes for the first line, and the block stays in IDLE afterwards.
- `reset` pulsed after 400 writes, then a fresh request with `nextVPos` = 0 -> all outputs 0 during reset, stale returns are not written, and the new line starts at address 0.
